// File: rtl/tone_seq_gen.sv
// Programmable square-wave tone generator: 12 semitones x (OCT_MAX+1) octaves
// with timed playback, stop, glitch-free retrigger and illegal-code flag.
module tone_seq_gen #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned OCT_MAX = 6,
   parameter int unsigned DUR_W   = 12,
   parameter int unsigned HP_W    = 20
) (
   input  logic             clk,
   input  logic             rb,
   input  logic             start,
   input  logic             stop,
   input  logic [3:0]       note,
   input  logic [2:0]       octave,
   input  logic [DUR_W-1:0] dur,
   output logic             out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned N_NOTES = 12;
   localparam int unsigned MS_CYC  = CLK_HZ / 1000;
   localparam int unsigned TICK_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MS_CYC - 1);

   typedef logic [N_NOTES-1:0][HP_W-1:0] rom_t;
   typedef enum logic {S_IDLE, S_PLAY} state_t;

   // Equal-tempered ratio of semitone n to A (2^((n-9)/12)).
   function automatic real ratio_of(input int unsigned n);
      case (n)
         0:       ratio_of = 0.5946035575013605;
         1:       ratio_of = 0.6299605249474366;
         2:       ratio_of = 0.6674199270850172;
         3:       ratio_of = 0.7071067811865476;
         4:       ratio_of = 0.7491535384383408;
         5:       ratio_of = 0.7937005259840998;
         6:       ratio_of = 0.8408964152537145;
         7:       ratio_of = 0.8908987181403393;
         8:       ratio_of = 0.9438743126816935;
         9:       ratio_of = 1.0;
         10:      ratio_of = 1.0594630943592953;
         default: ratio_of = 1.1224620483093730;
      endcase
   endfunction

   // Great-octave half-periods in clock cycles, rounded to nearest.
   function automatic rom_t build_rom();
      rom_t rom;
      rom = '0;
      for (int unsigned n = 0; n < N_NOTES; n++) begin
         rom[4'(n)] = HP_W'($rtoi(real'(CLK_HZ) / (220.0 * ratio_of(n)) + 0.5));
      end
      return rom;
   endfunction

   localparam rom_t BASE = build_rom();

   state_t             r_state,    w_state_nxt;
   logic               r_out,      w_out_nxt;
   logic               r_busy,     w_busy_nxt;
   logic               r_done,     w_done_nxt;
   logic               r_err,      w_err_nxt;
   logic [HP_W-1:0]    r_hp_cnt,   w_hp_cnt_nxt;
   logic [HP_W-1:0]    r_hp_cur,   w_hp_cur_nxt;
   logic [HP_W-1:0]    r_hp_pend,  w_hp_pend_nxt;
   logic               r_pend_vld, w_pend_vld_nxt;
   logic [DUR_W-1:0]   r_ms_cnt,   w_ms_cnt_nxt;
   logic [TICK_W-1:0]  r_tick_cnt, w_tick_cnt_nxt;

   logic               w_legal;
   logic [3:0]         w_idx;
   logic [HP_W-1:0]    w_h;
   logic               w_tick;
   logic               w_hp_exp;
   logic               w_timeout;
   logic               w_retrig;
   logic               w_end;

   assign w_legal   = (note <= 4'd11) && (32'(octave) <= OCT_MAX);
   assign w_idx     = (note <= 4'd11) ? note : 4'd0;
   assign w_h       = BASE[w_idx] >> octave;
   assign w_tick    = (r_tick_cnt == TICK_LAST);
   assign w_hp_exp  = (r_hp_cnt == HP_W'(1));
   assign w_timeout = w_tick && (r_ms_cnt == DUR_W'(1));
   // stop beats start; a legal start beats a same-cycle timeout
   assign w_retrig  = start && w_legal && !stop;
   assign w_end     = stop || (w_timeout && !w_retrig);

   always_comb begin
      w_state_nxt    = r_state;
      w_out_nxt      = r_out;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_err_nxt      = 1'b0;
      w_hp_cnt_nxt   = r_hp_cnt;
      w_hp_cur_nxt   = r_hp_cur;
      w_hp_pend_nxt  = r_hp_pend;
      w_pend_vld_nxt = r_pend_vld;
      w_ms_cnt_nxt   = r_ms_cnt;
      w_tick_cnt_nxt = w_tick ? '0 : r_tick_cnt + TICK_W'(1);

      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               if (w_legal) begin
                  w_state_nxt    = S_PLAY;
                  w_out_nxt      = 1'b1;
                  w_busy_nxt     = 1'b1;
                  w_hp_cnt_nxt   = w_h;
                  w_hp_cur_nxt   = w_h;
                  w_pend_vld_nxt = 1'b0;
                  w_ms_cnt_nxt   = dur;
                  w_tick_cnt_nxt = '0;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_PLAY: begin
            // A pending pitch is adopted only at a half-period boundary.
            if (w_hp_exp) begin
               w_out_nxt = ~r_out;
               if (r_pend_vld) begin
                  w_hp_cnt_nxt   = r_hp_pend;
                  w_hp_cur_nxt   = r_hp_pend;
                  w_pend_vld_nxt = 1'b0;
               end else begin
                  w_hp_cnt_nxt = r_hp_cur;
               end
            end else begin
               w_hp_cnt_nxt = r_hp_cnt - HP_W'(1);
            end
            if (w_tick && (r_ms_cnt > DUR_W'(1))) begin
               w_ms_cnt_nxt = r_ms_cnt - DUR_W'(1);
            end
            if (start && !w_legal && !stop) begin
               w_err_nxt = 1'b1;
            end
            if (w_end) begin
               w_state_nxt    = S_IDLE;
               w_out_nxt      = 1'b0;
               w_busy_nxt     = 1'b0;
               w_done_nxt     = 1'b1;
               w_hp_cnt_nxt   = '0;
               w_pend_vld_nxt = 1'b0;
               w_ms_cnt_nxt   = '0;
            end else if (w_retrig) begin
               w_hp_pend_nxt  = w_h;
               w_pend_vld_nxt = 1'b1;
               w_ms_cnt_nxt   = dur;
               w_tick_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rb) begin
      if (!rb) begin
         r_state    <= S_IDLE;
         r_out      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_hp_cnt   <= '0;
         r_hp_cur   <= '0;
         r_hp_pend  <= '0;
         r_pend_vld <= 1'b0;
         r_ms_cnt   <= '0;
         r_tick_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_out      <= w_out_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_hp_cnt   <= w_hp_cnt_nxt;
         r_hp_cur   <= w_hp_cur_nxt;
         r_hp_pend  <= w_hp_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_ms_cnt   <= w_ms_cnt_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

endmodule

// File: tb/tb_tone_seq_gen.sv
// Scoreboard bench for tone_seq_gen at a 2 MHz clock (2000 cycles per ms):
// expected output edges/pulses are queued with their cycle, a monitor compares.
module tb_tone_seq_gen;

   localparam int unsigned CLK_HZ = 2_000_000;
   // BASE at 2 MHz: C=15289, A=9091, B=8099
   localparam int H_A2 = 2272;   // 9091 >> 2
   localparam int H_C4 = 955;    // 15289 >> 4
   localparam int H_C6 = 238;    // 15289 >> 6
   localparam int MS   = 2000;

   typedef enum int {E_OUT_R, E_OUT_F, E_BUSY_R, E_BUSY_F, E_DONE, E_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rb = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [3:0]  note = 4'd0;
   logic [2:0]  octave = 3'd0;
   logic [11:0] dur = 12'd0;
   logic        out, busy, done, err;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   ev_t q[$];
   logic prev_out = 1'b0;
   logic prev_busy = 1'b0;

   tone_seq_gen #(.CLK_HZ(CLK_HZ)) dut (
      .clk(clk), .rb(rb), .start(start), .stop(stop),
      .note(note), .octave(octave), .dur(dur),
      .out(out), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Insert keeping queue ordered by cycle, then by monitor observation order.
   task automatic exp_ev(input ev_kind_t k, input int c);
      ev_t e;
      int  i;
      e.kind = k;
      e.cyc  = c;
      i = 0;
      while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].kind <= k))) i++;
      q.insert(i, e);
   endtask

   task automatic observe(input ev_kind_t k);
      ev_t e;
      n_tests++;
      if (q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: actual event at cycle %0d, required none", k.name(), cyc);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL event_%s: actual %s at cycle %0d, required %s at cycle %0d",
                     e.kind.name(), k.name(), cyc, e.kind.name(), e.cyc);
         end
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %b, required %b", name, act, req);
      end
   endtask

   // Drive a request at the negedge of cycle t; it is sampled at the next posedge.
   task automatic apply(input int t, input logic s, input logic p, input logic [3:0] n,
                        input logic [2:0] o, input logic [11:0] d, output int c);
      while (cyc < t) @(negedge clk);
      start  = s;
      stop   = p;
      note   = n;
      octave = o;
      dur    = d;
      c      = cyc;
   endtask

   task automatic idle_in();
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rb) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            ev_t m;
            m = q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_%s: actual none by cycle %0d, required at cycle %0d",
                     m.kind.name(), cyc, m.cyc);
         end
         if (out != prev_out)   observe(out  ? E_OUT_R  : E_OUT_F);
         if (busy != prev_busy) observe(busy ? E_BUSY_R : E_BUSY_F);
         if (done)              observe(E_DONE);
         if (err)               observe(E_ERR);
      end
      prev_out  = out;
      prev_busy = busy;
   end

   initial begin
      int c, c2;
      repeat (3) @(negedge clk);
      check1("reset_out", out, 1'b0);
      check1("reset_busy", busy, 1'b0);
      check1("reset_done", done, 1'b0);
      check1("reset_err", err, 1'b0);
      rb = 1'b1;

      // A, octave 2, 2 ms: high H, low until done at k+1+2ms
      apply(cyc + 2, 1'b1, 1'b0, 4'd9, 3'd2, 12'd2, c);
      exp_ev(E_OUT_R, c + 1);  exp_ev(E_BUSY_R, c + 1);
      exp_ev(E_OUT_F, c + 1 + H_A2);
      exp_ev(E_BUSY_F, c + 1 + 2 * MS);  exp_ev(E_DONE, c + 1 + 2 * MS);
      idle_in();
      wait_to(c + 2 * MS + 100);

      // Illegal note and illegal octave in IDLE
      apply(cyc + 2, 1'b1, 1'b0, 4'd12, 3'd2, 12'd1, c);
      exp_ev(E_ERR, c + 1);
      idle_in();
      apply(cyc + 3, 1'b1, 1'b0, 4'd9, 3'd7, 12'd1, c);
      exp_ev(E_ERR, c + 1);
      idle_in();
      wait_to(cyc + 10);

      // A2 forever; illegal start while playing; retrigger to C oct4 mid half-period
      apply(cyc + 2, 1'b1, 1'b0, 4'd9, 3'd2, 12'd0, c);
      exp_ev(E_OUT_R, c + 1);  exp_ev(E_BUSY_R, c + 1);
      exp_ev(E_OUT_F, c + 1 + H_A2);
      exp_ev(E_OUT_R, c + 1 + 2 * H_A2);
      exp_ev(E_OUT_F, c + 1 + 2 * H_A2 + H_C4);
      exp_ev(E_OUT_R, c + 1 + 2 * H_A2 + 2 * H_C4);
      exp_ev(E_OUT_F, c + 1 + 2 * H_A2 + 3 * H_C4);
      idle_in();
      apply(c + 1000, 1'b1, 1'b0, 4'd15, 3'd2, 12'd0, c2);
      exp_ev(E_ERR, c2 + 1);
      idle_in();
      apply(c + 3000, 1'b1, 1'b0, 4'd0, 3'd4, 12'd0, c2);
      idle_in();
      apply(c + 7500, 1'b0, 1'b1, 4'd0, 3'd0, 12'd0, c2);
      exp_ev(E_BUSY_F, c2 + 1);  exp_ev(E_DONE, c2 + 1);
      idle_in();
      wait_to(c2 + 1500);

      // Highest C, continuous for over 1 ms, stopped while out is high
      apply(cyc + 2, 1'b1, 1'b0, 4'd0, 3'd6, 12'd0, c);
      exp_ev(E_OUT_R, c + 1);  exp_ev(E_BUSY_R, c + 1);
      for (int i = 1; i <= 10; i++)
         exp_ev((i % 2 == 1) ? E_OUT_F : E_OUT_R, c + 1 + H_C6 * i);
      idle_in();
      apply(c + 2430, 1'b0, 1'b1, 4'd0, 3'd0, 12'd0, c2);
      exp_ev(E_OUT_F, c2 + 1);  exp_ev(E_BUSY_F, c2 + 1);  exp_ev(E_DONE, c2 + 1);
      idle_in();
      wait_to(c2 + 500);

      // start + stop together while playing: stop wins, no retrigger, no err
      apply(cyc + 2, 1'b1, 1'b0, 4'd9, 3'd2, 12'd0, c);
      exp_ev(E_OUT_R, c + 1);  exp_ev(E_BUSY_R, c + 1);
      idle_in();
      apply(c + 100, 1'b1, 1'b1, 4'd0, 3'd4, 12'd5, c2);
      exp_ev(E_OUT_F, c2 + 1);  exp_ev(E_BUSY_F, c2 + 1);  exp_ev(E_DONE, c2 + 1);
      idle_in();
      wait_to(c + 3000);

      // Legal start in the timeout cycle retriggers: done moves out by 1 ms
      apply(cyc + 2, 1'b1, 1'b0, 4'd9, 3'd2, 12'd1, c);
      exp_ev(E_OUT_R, c + 1);  exp_ev(E_BUSY_R, c + 1);
      exp_ev(E_OUT_F, c + 1 + H_A2);
      exp_ev(E_BUSY_F, c + 1 + 2 * MS);  exp_ev(E_DONE, c + 1 + 2 * MS);
      idle_in();
      apply(c + MS, 1'b1, 1'b0, 4'd9, 3'd2, 12'd1, c2);
      idle_in();
      wait_to(c + 2 * MS + 200);

      // Asynchronous reset mid-playback: outputs drop before the next edge, no done
      apply(cyc + 2, 1'b1, 1'b0, 4'd9, 3'd2, 12'd0, c);
      exp_ev(E_OUT_R, c + 1);  exp_ev(E_BUSY_R, c + 1);
      idle_in();
      wait_to(c + 100);
      #2 rb = 1'b0;
      #1;
      check1("async_rst_out", out, 1'b0);
      check1("async_rst_busy", busy, 1'b0);
      check1("async_rst_done", done, 1'b0);
      repeat (3) @(negedge clk);
      check1("rst_hold_done", done, 1'b0);
      rb = 1'b1;
      wait_to(c + 3000);

      while (q.size() > 0) begin
         ev_t m;
         m = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_%s: actual none, required at cycle %0d", m.kind.name(), m.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
